pipe_skid_stage: RTL and testbench

//  Parametrised inter-stage pipeline register (ex->ls and later stages) with valid/ready handshake.
//  Up to two entries of skid buffering, synchronous flush, and bubble-safe write-enable masking.

---
 rtl/pipe_skid_stage_pkg.sv | 22 ++
 rtl/pipe_skid_stage_if.sv | 34 +++
 rtl/pipe_skid_stage_entry.sv | 40 ++++
 rtl/pipe_skid_stage.sv | 156 +++++++++++++++
 tb/tb_pipe_skid_stage.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_skid_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_stage_pkg
// Description : Shared constants for the inter-stage skid register.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_skid_stage_pkg;

    // Width of the concatenated ex->ls payload.
    localparam int unsigned c_stage_payload_w = 128;

    // Write-enable side-band bit positions.
    localparam int unsigned c_we_rd  = 0;
    localparam int unsigned c_we_csr = 1;

    // State encoding doubles as the occupancy count.
    localparam logic [1:0] c_st_empty = 2'd0;
    localparam logic [1:0] c_st_one   = 2'd1;
    localparam logic [1:0] c_st_full  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/pipe_skid_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_stage_if
// Description : Upstream/downstream handshake bundle of one pipeline stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_skid_stage_if
    import pipe_skid_stage_pkg::*;
#(
    parameter int unsigned DATA_W = c_stage_payload_w,
    parameter int unsigned WE_W   = 2
);
    logic              flush_i;
    logic              up_valid_i;
    logic              up_ready_o;
    logic [DATA_W-1:0] up_data_i;
    logic [WE_W-1:0]   up_we_i;
    logic              dn_valid_o;
    logic              dn_ready_i;
    logic [DATA_W-1:0] dn_data_o;
    logic [WE_W-1:0]   dn_we_o;
    logic [1:0]        occ_o;

    modport master (
        output flush_i, up_valid_i, up_data_i, up_we_i, dn_ready_i,
        input  up_ready_o, dn_valid_o, dn_data_o, dn_we_o, occ_o
    );

    modport slave (
        input  flush_i, up_valid_i, up_data_i, up_we_i, dn_ready_i,
        output up_ready_o, dn_valid_o, dn_data_o, dn_we_o, occ_o
    );
endinterface
`default_nettype wire

// File: rtl/pipe_skid_stage_entry.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_stage_entry
// Description : One payload + write-enable register with load and clear.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_stage_entry #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned WE_W   = 2
) (
    input  wire              clk,
    input  wire              rst,
    input  wire              i_load,
    input  wire              i_clear,
    input  wire [DATA_W-1:0] i_data,
    input  wire [WE_W-1:0]   i_we,
    output logic [DATA_W-1:0] o_data,
    output logic [WE_W-1:0]   o_we
);
    logic [DATA_W-1:0] r_data;
    logic [WE_W-1:0]   r_we;

    // Load wins over clear so a same-cycle refill is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
            r_we   <= '0;
        end else if (i_load) begin
            r_data <= i_data;
            r_we   <= i_we;
        end else if (i_clear) begin
            r_data <= '0;
            r_we   <= '0;
        end
    end

    assign o_data = r_data;
    assign o_we   = r_we;
endmodule
`default_nettype wire

// File: rtl/pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_stage
// Description : Valid/ready pipeline register with optional 2-entry skid and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_stage
    import pipe_skid_stage_pkg::*;
#(
    parameter int unsigned DATA_W   = c_stage_payload_w,
    parameter int unsigned WE_W     = 2,
    parameter int unsigned SKID_EN  = 1,
    parameter int unsigned CLR_DATA = 1
) (
    input wire                clk,
    input wire                rst,
    pipe_skid_stage_if.slave  bus
);
    localparam logic c_clr_en = (CLR_DATA != 0);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              w_push;
    logic              w_pop;
    logic              w_dn_valid;
    logic              w_up_ready;
    logic              w_m_load;
    logic              w_m_from_s;
    logic              w_m_clear;
    logic              w_s_load;
    logic              w_s_clear;
    logic              w_m_clr_g;
    logic              w_s_clr_g;
    logic [DATA_W-1:0] w_m_data_in;
    logic [WE_W-1:0]   w_m_we_in;
    logic [DATA_W-1:0] w_m_data;
    logic [WE_W-1:0]   w_m_we;
    logic [DATA_W-1:0] w_s_data;
    logic [WE_W-1:0]   w_s_we;

    assign w_dn_valid = (r_state != c_st_empty);

    generate
        if (SKID_EN != 0) begin : g_ready_reg
            // Depends on state flops only: downstream ready never reaches upstream.
            assign w_up_ready = (r_state != c_st_full);
        end else begin : g_ready_comb
            assign w_up_ready = !w_dn_valid || bus.dn_ready_i;
        end
    endgenerate

    assign w_push = bus.up_valid_i & w_up_ready;
    assign w_pop  = w_dn_valid & bus.dn_ready_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_empty;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_m_load    = 1'b0;
        w_m_from_s  = 1'b0;
        w_m_clear   = 1'b0;
        w_s_load    = 1'b0;
        w_s_clear   = 1'b0;
        if (bus.flush_i) begin
            w_state_nxt = c_st_empty;
            w_m_clear   = 1'b1;
            w_s_clear   = 1'b1;
        end else begin
            case (r_state)
                c_st_empty: begin
                    if (w_push) begin
                        w_m_load    = 1'b1;
                        w_state_nxt = c_st_one;
                    end
                end
                c_st_one: begin
                    if (w_push && w_pop) begin
                        w_m_load = 1'b1;
                    end else if (w_push) begin
                        w_s_load    = 1'b1;
                        w_state_nxt = c_st_full;
                    end else if (w_pop) begin
                        w_m_clear   = 1'b1;
                        w_state_nxt = c_st_empty;
                    end
                end
                c_st_full: begin
                    if (w_pop) begin
                        w_m_load    = 1'b1;
                        w_m_from_s  = 1'b1;
                        w_s_clear   = 1'b1;
                        w_state_nxt = c_st_one;
                    end
                end
                default: begin
                    w_state_nxt = c_st_empty;
                end
            endcase
        end
    end

    assign w_m_clr_g   = w_m_clear & c_clr_en;
    assign w_s_clr_g   = w_s_clear & c_clr_en;
    assign w_m_data_in = w_m_from_s ? w_s_data : bus.up_data_i;
    assign w_m_we_in   = w_m_from_s ? w_s_we   : bus.up_we_i;

    pipe_skid_stage_entry #(
        .DATA_W (DATA_W),
        .WE_W   (WE_W)
    ) u_main (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_m_load),
        .i_clear (w_m_clr_g),
        .i_data  (w_m_data_in),
        .i_we    (w_m_we_in),
        .o_data  (w_m_data),
        .o_we    (w_m_we)
    );

    generate
        if (SKID_EN != 0) begin : g_skid
            pipe_skid_stage_entry #(
                .DATA_W (DATA_W),
                .WE_W   (WE_W)
            ) u_skid (
                .clk     (clk),
                .rst     (rst),
                .i_load  (w_s_load),
                .i_clear (w_s_clr_g),
                .i_data  (bus.up_data_i),
                .i_we    (bus.up_we_i),
                .o_data  (w_s_data),
                .o_we    (w_s_we)
            );
        end else begin : g_no_skid
            logic w_unused_skid;
            assign w_s_data      = '0;
            assign w_s_we        = '0;
            assign w_unused_skid = w_s_load ^ w_s_clr_g;
        end
    endgenerate

    assign bus.up_ready_o = w_up_ready;
    assign bus.dn_valid_o = w_dn_valid;
    assign bus.dn_data_o  = w_m_data;
    assign bus.dn_we_o    = w_m_we & {WE_W{w_dn_valid}};
    assign bus.occ_o      = r_state;
endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_skid_stage
// Description : Directed + random bench for skid (SKID_EN=1) and plain (SKID_EN=0) stages.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_stage;
    import pipe_skid_stage_pkg::*;

    localparam int unsigned DW = 128;
    localparam int unsigned WW = 2;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [WW-1:0] we;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          vld = 1'b0;
    logic          fls = 1'b0;
    logic          drdy = 1'b0;
    logic [DW-1:0] dat = '0;
    logic [WW-1:0] wen = '0;

    int n_assert = 0;
    int n_fail   = 0;

    ent_t q_s[$];
    ent_t q_n[$];

    always #5 clk = ~clk;

    pipe_skid_stage_if #(.DATA_W(DW), .WE_W(WW)) ifs ();
    pipe_skid_stage_if #(.DATA_W(DW), .WE_W(WW)) ifn ();

    assign ifs.flush_i    = fls;
    assign ifs.up_valid_i = vld;
    assign ifs.up_data_i  = dat;
    assign ifs.up_we_i    = wen;
    assign ifs.dn_ready_i = drdy;
    assign ifn.flush_i    = fls;
    assign ifn.up_valid_i = vld;
    assign ifn.up_data_i  = dat;
    assign ifn.up_we_i    = wen;
    assign ifn.dn_ready_i = drdy;

    pipe_skid_stage #(.DATA_W(DW), .WE_W(WW), .SKID_EN(1), .CLR_DATA(1)) u_dut_skid (
        .clk (clk),
        .rst (rst),
        .bus (ifs.slave)
    );

    pipe_skid_stage #(.DATA_W(DW), .WE_W(WW), .SKID_EN(0), .CLR_DATA(1)) u_dut_reg (
        .clk (clk),
        .rst (rst),
        .bus (ifn.slave)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outputs follow from queue contents: head is shown, empty shows zeros.
    task automatic check_all(input string tag);
        ent_t hs;
        ent_t hn;
        hs = '0;
        hn = '0;
        if (q_s.size() != 0) hs = q_s[0];
        if (q_n.size() != 0) hn = q_n[0];
        chk({tag, ".s.valid"}, ifs.dn_valid_o, q_s.size() != 0);
        chk({tag, ".s.data"},  ifs.dn_data_o,  hs.d);
        chk({tag, ".s.we"},    ifs.dn_we_o,    hs.we);
        chk({tag, ".s.occ"},   ifs.occ_o,      q_s.size());
        chk({tag, ".s.ready"}, ifs.up_ready_o, q_s.size() < 2);
        chk({tag, ".n.valid"}, ifn.dn_valid_o, q_n.size() != 0);
        chk({tag, ".n.data"},  ifn.dn_data_o,  hn.d);
        chk({tag, ".n.we"},    ifn.dn_we_o,    hn.we);
        chk({tag, ".n.occ"},   ifn.occ_o,      q_n.size());
        chk({tag, ".n.ready"}, ifn.up_ready_o, (q_n.size() == 0) || drdy);
    endtask

    task automatic step(input logic v, input logic [DW-1:0] d, input logic [WW-1:0] we,
                        input logic r, input logic f, input string tag);
        bit   push_s, pop_s, push_n, pop_n;
        ent_t e;
        vld  = v;
        dat  = d;
        wen  = we;
        drdy = r;
        fls  = f;
        #1;
        check_all(tag);
        push_s = v && (q_s.size() < 2);
        pop_s  = r && (q_s.size() != 0);
        push_n = v && ((q_n.size() == 0) || r);
        pop_n  = r && (q_n.size() != 0);
        e.d  = d;
        e.we = we;
        @(posedge clk);
        if (f) begin
            q_s.delete();
            q_n.delete();
        end else begin
            if (pop_s) void'(q_s.pop_front());
            if (push_s) q_s.push_back(e);
            if (pop_n) void'(q_n.pop_front());
            if (push_n) q_n.push_back(e);
        end
        #1;
    endtask

    task automatic async_reset_pulse();
        #2;
        rst = 1'b1;
        #1;
        q_s.delete();
        q_n.delete();
        check_all("arst");
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [WW-1:0] we_both;
        int            p_v;
        int            p_r;
        we_both          = '0;
        we_both[c_we_rd]  = 1'b1;
        we_both[c_we_csr] = 1'b1;
        p_v = 50;
        p_r = 50;

        // 1: reset and idle
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;
        step(1'b0, '0, '0, 1'b0, 1'b0, "idle");
        step(1'b0, '0, '0, 1'b0, 1'b0, "idle");
        chk("t1.rdy", ifs.up_ready_o, 1);
        chk("t1.occ", ifs.occ_o, 0);

        // 2: streaming
        step(1'b1, 128'd1, '0, 1'b1, 1'b0, "stream");
        chk("t2.d1", ifs.dn_data_o, 1);
        step(1'b1, 128'd2, '0, 1'b1, 1'b0, "stream");
        chk("t2.d2", ifs.dn_data_o, 2);
        step(1'b1, 128'd3, '0, 1'b1, 1'b0, "stream");
        chk("t2.d3", ifs.dn_data_o, 3);
        chk("t2.occ", ifs.occ_o, 1);
        step(1'b0, '0, '0, 1'b1, 1'b0, "stream");

        // 3: backpressure into the skid slot
        step(1'b1, 128'hA5, '0, 1'b0, 1'b0, "bp");
        step(1'b1, 128'h5A, '0, 1'b0, 1'b0, "bp");
        chk("t3.occ", ifs.occ_o, 2);
        chk("t3.rdy", ifs.up_ready_o, 0);
        chk("t3.head", ifs.dn_data_o, 128'hA5);
        step(1'b0, '0, '0, 1'b1, 1'b0, "bp_drain");
        chk("t3.second", ifs.dn_data_o, 128'h5A);
        step(1'b0, '0, '0, 1'b1, 1'b0, "bp_drain");
        step(1'b0, '0, '0, 1'b1, 1'b0, "bp_drain");

        // 4: flush while full with a live upstream entry
        step(1'b1, 128'h11, we_both, 1'b0, 1'b0, "fl_fill");
        step(1'b1, 128'h22, 2'b01, 1'b0, 1'b0, "fl_fill");
        step(1'b1, 128'h77, we_both, 1'b0, 1'b1, "flush");
        chk("t4.occ", ifs.occ_o, 0);
        chk("t4.valid", ifs.dn_valid_o, 0);
        chk("t4.we", ifs.dn_we_o, 0);
        chk("t4.data", ifs.dn_data_o, 0);
        step(1'b0, '0, '0, 1'b1, 1'b0, "post_flush");
        chk("t4.gone", ifs.dn_valid_o, 0);

        // 5: bubble after a pop must not carry write enables
        step(1'b1, 128'h33, we_both, 1'b1, 1'b0, "bubble");
        chk("t5.we_live", ifs.dn_we_o, 2'b11);
        step(1'b0, '0, '0, 1'b1, 1'b0, "bubble");
        chk("t5.we_bubble", ifs.dn_we_o, 2'b00);

        // 6: plain register ready follows downstream ready combinationally
        step(1'b1, 128'h44, '0, 1'b0, 1'b0, "plain");
        vld  = 1'b0;
        drdy = 1'b0;
        #1;
        chk("t6.rdy_lo", ifn.up_ready_o, 0);
        drdy = 1'b1;
        #1;
        chk("t6.rdy_hi", ifn.up_ready_o, 1);
        step(1'b1, 128'h55, '0, 1'b1, 1'b0, "plain");
        chk("t6.occ", ifn.occ_o, 1);
        chk("t6.data", ifn.dn_data_o, 128'h55);
        step(1'b0, '0, '0, 1'b1, 1'b0, "plain");

        // Random traffic with flush and async reset pulses
        for (int i = 0; i < 10000; i++) begin
            if ((i % 256) == 0) begin
                p_v = $urandom_range(20, 100);
                p_r = $urandom_range(10, 100);
            end
            if ($urandom_range(0, 999) == 0) begin
                async_reset_pulse();
            end else begin
                step($urandom_range(1, 100) <= p_v,
                     {$urandom, $urandom, $urandom, $urandom},
                     WW'($urandom),
                     $urandom_range(1, 100) <= p_r,
                     $urandom_range(0, 99) == 0,
                     "rnd");
            end
        end
        step(1'b0, '0, '0, 1'b1, 1'b0, "drain");
        step(1'b0, '0, '0, 1'b1, 1'b0, "drain");
        step(1'b0, '0, '0, 1'b1, 1'b0, "drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
